// File: rtl/sram_loader_pkg.sv
// Shared types and constants for the boot-time SRAM program loader.
package sram_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int         LEN_W        = 16;

endpackage

// File: rtl/sram_loader.sv
// Framed UART byte stream to SRAM word loader; holds the core off the
// SRAM port until a frame with a good checksum has been written.
module sram_loader
    import sram_loader_pkg::*;
#(
    parameter int         WIDTH      = 32,
    parameter int         DEPTH      = 256,
    parameter int         ADDR_WIDTH = $clog2(DEPTH),
    parameter logic [7:0] SYNC       = SYNC_DEFAULT,
    parameter int         TIMEOUT    = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic                  mem_we,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int BYTES = WIDTH / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH);
    localparam logic [BW-1:0]    LAST_IDX = BW'(BYTES - 1);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic                    rx_ready_q, rx_ready_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]        word_q, word_d;
    logic [BW-1:0]           idx_q, idx_d;
    logic [7:0]              sum_q, sum_d;
    logic [7:0]              len_lo_q, len_lo_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    error_q, error_d;

    logic                    acc;
    logic                    counting;
    logic                    tmo_hit;
    logic                    last_word;
    logic [LEN_W-1:0]        len_in;

    assign acc      = rx_valid && rx_ready_q;
    assign len_in   = {rx_data, len_lo_q};
    assign counting = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA)   || (state_q == S_CSUM);
    assign tmo_hit  = counting && !acc && (tmo_q == TMO_LAST);
    assign last_word = (LEN_W'(addr_q) + LEN_W'(1)) == len_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rx_ready_q <= 1'b0;
            addr_q     <= '0;
            word_q     <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            len_lo_q   <= '0;
            len_q      <= '0;
            tmo_q      <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= rx_ready_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            tmo_q      <= tmo_d;
            error_q    <= error_d;
        end
    end

    // A failed frame drops straight back to IDLE; error_q records it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (acc && rx_data == SYNC)
                    state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (tmo_hit)
                    state_d = S_IDLE;
                else if (acc)
                    state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (tmo_hit)
                    state_d = S_IDLE;
                else if (acc) begin
                    if (len_in > DEPTH_L)
                        state_d = S_IDLE;
                    else if (len_in == '0)
                        state_d = S_CSUM;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tmo_hit)
                    state_d = S_IDLE;
                else if (acc && idx_q == LAST_IDX)
                    state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = last_word ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (tmo_hit)
                    state_d = S_IDLE;
                else if (acc)
                    state_d = (rx_data == sum_q) ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rx_ready_d = (state_d != S_WRITE);
        addr_d     = addr_q;
        word_d     = word_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        error_d    = error_q;
        tmo_d      = (!counting || acc) ? '0 : tmo_q + 1'b1;

        if (tmo_hit)
            error_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (acc && rx_data == SYNC) begin
                    error_d = 1'b0;
                    addr_d  = '0;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            S_LEN_LO: begin
                if (acc) begin
                    len_lo_d = rx_data;
                    sum_d    = sum_q + rx_data;
                end
            end
            S_LEN_HI: begin
                if (acc) begin
                    len_d = len_in;
                    sum_d = sum_q + rx_data;
                    if (len_in > DEPTH_L)
                        error_d = 1'b1;
                end
            end
            S_DATA: begin
                if (acc) begin
                    // First byte of a word ends up in bits 7:0.
                    word_d = (word_q >> 8) |
                             (WIDTH'(rx_data) << (WIDTH - 8));
                    sum_d  = sum_q + rx_data;
                    idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                end
            end
            S_WRITE: begin
                if (!last_word)
                    addr_d = addr_q + 1'b1;
            end
            S_CSUM: begin
                if (acc && rx_data != sum_q)
                    error_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        mem_we    = (state_q == S_WRITE);
        cpu_hold  = (state_q != S_DONE);
        done      = (state_q == S_DONE);
        error     = error_q;
        rx_ready  = rx_ready_q;
        mem_addr  = addr_q;
        mem_wdata = word_q;
    end

endmodule
